// File: rtl/lane_car_counter_pkg.sv
// lane_car_counter_pkg
//   Shared constants for the lane car counter: lane bit positions in the
//   packed lane vectors, count width, debounce FSM state encoding, and the
//   modulo-16 counter increment helper.
package lane_car_counter_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_NS   = 3;
  localparam int LANE_SN   = 2;
  localparam int LANE_EW   = 1;
  localparam int LANE_WE   = 0;

  localparam int CNT_W     = 4;

  // Bit 1 of the state is the filtered level: 1 in HIGH and WAIT_LOW.
  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  // Wraps 15 -> 0 naturally through the fixed width.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce
//   One lane front end: 2-flop synchronizer, debounce FSM and a rise strobe
//   that marks the cycle the filtered level goes 0 -> 1.
//   Macro LANE_CAR_DEBOUNCE_EN: defined -> FSM filter compiled in;
//   undefined -> filtered level is the synchronized input.
// Ports:
//   clk, reset  clock, async active-high reset
//   sensor      raw asynchronous sensor
//   rise        combinational from registers only: the next edge is the
//               filtered rising edge (registered by the parent)
module sensor_debounce
  import lane_car_counter_pkg::*;
#(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic rise
);

  logic sync_q1, sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sensor;
      sync_q2 <= sync_q1;
    end
  end

`ifdef LANE_CAR_DEBOUNCE_EN
  // The entry sample plus DEB_CYCLES further stable samples qualify a level.
  localparam logic [7:0] STAB_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] stab_q, stab_d;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    rise    = 1'b0;
    case (state_q)
      ST_LOW:
        if (sync_q2) begin
          state_d = ST_WAIT_HIGH;
          stab_d  = '0;
        end
      ST_WAIT_HIGH:
        if (!sync_q2)                state_d = ST_LOW;
        else if (stab_q == STAB_LAST) begin
          state_d = ST_HIGH;
          rise    = 1'b1;
        end else                     stab_d  = stab_q + 8'd1;
      ST_HIGH:
        if (!sync_q2) begin
          state_d = ST_WAIT_LOW;
          stab_d  = '0;
        end
      ST_WAIT_LOW:
        // Bouncing back to HIGH is not a new vehicle: no rise here.
        if (sync_q2)                 state_d = ST_HIGH;
        else if (stab_q == STAB_LAST) state_d = ST_LOW;
        else                         stab_d  = stab_q + 8'd1;
      default:                       state_d = ST_LOW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOW;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end
`else
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= sync_q2;
  end

  assign rise = sync_q2 & ~prev_q;
`endif

endmodule

// File: rtl/lane_car_counter.sv
// lane_car_counter
//   Four independent lane vehicle counters. Each lane runs through a
//   sensor_debounce instance; its filtered rise bumps a 4-bit modulo-16
//   count and pulses the lane's car_evt bit for one cycle.
//   Macro LANE_CAR_DEBOUNCE_EN selects the debounce filter (see
//   sensor_debounce); default build has it disabled.
// Ports:
//   clk, reset                  clock, async active-high reset
//   sensor_ns/sn/ew/we          raw asynchronous lane sensors
//   clr                         synchronous clear of all counts (wins over
//                               a same-cycle increment)
//   count_{ns,sn,ew,we}_4b      registered lane counts
//   car_evt[3:0]                registered strobes {ns,sn,ew,we}
module lane_car_counter
  import lane_car_counter_pkg::*;
#(
  parameter int DEB_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_ns,
  input  logic             sensor_sn,
  input  logic             sensor_ew,
  input  logic             sensor_we,
  input  logic             clr,
  output logic [CNT_W-1:0] count_ns_4b,
  output logic [CNT_W-1:0] count_sn_4b,
  output logic [CNT_W-1:0] count_ew_4b,
  output logic [CNT_W-1:0] count_we_4b,
  output logic [3:0]       car_evt
);

  logic [NUM_LANES-1:0]            sensor, rise;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q;

  assign sensor[LANE_NS] = sensor_ns;
  assign sensor[LANE_SN] = sensor_sn;
  assign sensor[LANE_EW] = sensor_ew;
  assign sensor[LANE_WE] = sensor_we;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .sensor (sensor[l]),
      .rise   (rise[l])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      car_evt <= '0;
    end else begin
      car_evt <= rise;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (clr)          cnt_q[l] <= '0;
        else if (rise[l]) cnt_q[l] <= cnt_inc(cnt_q[l]);
      end
    end
  end

  assign count_ns_4b = cnt_q[LANE_NS];
  assign count_sn_4b = cnt_q[LANE_SN];
  assign count_ew_4b = cnt_q[LANE_EW];
  assign count_we_4b = cnt_q[LANE_WE];

endmodule

// File: tb/tb_lane_car_counter.sv
module tb_lane_car_counter;

  localparam int DEB = 4;
`ifdef LANE_CAR_DEBOUNCE_EN
  localparam bit EN  = 1'b1;
  localparam int THR = DEB + 1;   // differing raw samples needed to flip the level
  localparam int LAT = DEB + 2;   // first sampled edge -> count/evt edge
`else
  localparam bit EN  = 1'b0;
  localparam int THR = 1;
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset, s_ns, s_sn, s_ew, s_we, clr;
  logic [3:0] c_ns, c_sn, c_ew, c_we, ev;

  always #5 clk = ~clk;

  lane_car_counter #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset),
    .sensor_ns(s_ns), .sensor_sn(s_sn), .sensor_ew(s_ew), .sensor_we(s_we),
    .clr(clr),
    .count_ns_4b(c_ns), .count_sn_4b(c_sn), .count_ew_4b(c_ew), .count_we_4b(c_we),
    .car_evt(ev)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each lane sees the raw sample from two edges earlier; its
  // filtered level flips once THR consecutive samples disagree with it.
  int d1[4], d2[4], filt[4], run[4], mcnt[4];
  int s_m;
  logic [3:0] mevt, ne, raw_v;
  assign raw_v = {s_ns, s_sn, s_ew, s_we};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 4; l++) begin
        d1[l] = 0; d2[l] = 0; filt[l] = 0; run[l] = 0; mcnt[l] = 0;
      end
      mevt = 4'd0;
    end else begin
      ne = 4'd0;
      for (int l = 0; l < 4; l++) begin
        s_m   = d2[l];
        d2[l] = d1[l];
        d1[l] = int'(raw_v[l]);
        if (s_m != filt[l]) begin
          run[l]++;
          if (run[l] == THR) begin
            filt[l] = s_m;
            run[l]  = 0;
            if (s_m == 1) ne[l] = 1'b1;
          end
        end else run[l] = 0;
        if (clr)        mcnt[l] = 0;
        else if (ne[l]) mcnt[l] = (mcnt[l] + 1) % 16;
      end
      mevt = ne;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cyc_evt",    ev,   mevt);
      chk("cyc_cnt_ns", c_ns, mcnt[3]);
      chk("cyc_cnt_sn", c_sn, mcnt[2]);
      chk("cyc_cnt_ew", c_ew, mcnt[1]);
      chk("cyc_cnt_we", c_we, mcnt[0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int first, npulse, other;

  initial begin
    reset = 1'b1; clr = 1'b0;
    s_ns = 1'b0; s_sn = 1'b0; s_ew = 1'b0; s_we = 1'b0;
    cyc(2);
    chk("reset_evt", ev, 0);
    chk("reset_cnt_ns", c_ns, 0);
    chk("reset_cnt_we", c_we, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    cyc(3);

    // Clean ew vehicle: single pulse at edge k+LAT, only on lane ew.
    s_ew = 1'b1;
    first = -1; npulse = 0; other = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (ev[1]) begin
        if (first < 0) first = j;
        npulse++;
      end
      if (ev[3] | ev[2] | ev[0]) other++;
    end
    @(negedge clk); s_ew = 1'b0;
    cyc(10);
    chk("ew_latency", first, LAT);
    chk("ew_pulses", npulse, 1);
    chk("ew_other_evt", other, 0);
    chk("ew_count", c_ew, 1);
    chk("ew_ns_count", c_ns, 0);
    chk("ew_sn_count", c_sn, 0);
    chk("ew_we_count", c_we, 0);

    // Short ns glitch: rejected by the filter, counted without it.
    s_ns = 1'b1; cyc(3); s_ns = 1'b0; cyc(10);
    chk("ns_glitch_count", c_ns, EN ? 0 : 1);

    // 17 clean we pulses: wrap 15 -> 0 -> 1.
    for (int p = 1; p <= 17; p++) begin
      s_we = 1'b1; cyc(8); s_we = 1'b0; cyc(8);
      if (p == 15) chk("we_after_15", c_we, 15);
      if (p == 16) chk("we_after_16", c_we, 0);
      if (p == 17) chk("we_after_17", c_we, 1);
    end

    // All lanes together.
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(2);
    chk("clr_ew", c_ew, 0);
    {s_ns, s_sn, s_ew, s_we} = 4'hF;
    first = -1; other = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (ev == 4'hF && first < 0) first = j;
      if (ev != 4'h0 && ev != 4'hF) other++;
    end
    @(negedge clk); {s_ns, s_sn, s_ew, s_we} = 4'h0;
    chk("all_latency", first, LAT);
    chk("all_split", other, 0);
    chk("all_cnt_ns", c_ns, 1);
    chk("all_cnt_sn", c_sn, 1);
    chk("all_cnt_ew", c_ew, 1);
    chk("all_cnt_we", c_we, 1);
    cyc(10);

    // Same again with clr on the event edge: clr wins.
    {s_ns, s_sn, s_ew, s_we} = 4'hF;
    cyc(LAT);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_edge_evt", ev, 15);
    @(negedge clk); clr = 1'b0;
    chk("clr_edge_ns", c_ns, 0);
    chk("clr_edge_sn", c_sn, 0);
    chk("clr_edge_ew", c_ew, 0);
    chk("clr_edge_we", c_we, 0);
    {s_ns, s_sn, s_ew, s_we} = 4'h0;
    cyc(10);

    // Reset while sn is mid-qualification.
    s_sn = 1'b1; cyc(8); s_sn = 1'b0; cyc(8);
    chk("sn_pre_reset", c_sn, 1);
    s_sn = 1'b1; cyc(4);
    #2 reset = 1'b1;
    #1;
    chk("sn_async_reset", c_sn, 0);
    chk("evt_async_reset", ev, 0);
    @(negedge clk); reset = 1'b0;
    first = -1;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (c_sn == 4'd1 && first < 0) first = j;
    end
    chk("sn_after_release", first, LAT);
    @(negedge clk); s_sn = 1'b0;
    cyc(10);
    chk("sn_final", c_sn, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_car_counter.md
LANE_CAR_COUNTER -- requirements
Module: lane_car_counter

Interface
REQ-001 Parameter DEB_CYCLES, default 8, is the number of consecutive stable synchronized samples required before a filtered sensor level changes (legal range 2..255).
REQ-002 clk  input  1  system clock; all state advances on its rising edge.
REQ-003 reset  input  1  reset; asynchronous and active-high.
REQ-004 sensor_ns  input  1  raw vehicle sensor, north-south lane; high means vehicle present; asynchronous to clk.
REQ-005 sensor_sn  input  1  raw vehicle sensor, south-north lane; same semantics.
REQ-006 sensor_ew  input  1  raw vehicle sensor, east-west lane; same semantics.
REQ-007 sensor_we  input  1  raw vehicle sensor, west-east lane; same semantics.
REQ-008 clr  input  1  synchronous clear of all four counts.
REQ-009 count_ns_4b  output  4  free-running vehicle count, north-south lane.
REQ-010 count_sn_4b  output  4  free-running vehicle count, south-north lane.
REQ-011 count_ew_4b  output  4  free-running vehicle count, east-west lane.
REQ-012 count_we_4b  output  4  free-running vehicle count, west-east lane.
REQ-013 car_evt  output  4  one-cycle strobe per lane; bit order {ns,sn,ew,we} = [3:0].

Function
REQ-014 Each lane: 2-flop synchronizer -> debounce FSM -> rising-edge detect -> 4-bit counter; lanes are fully independent.
REQ-015 Debounce FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW; the filtered level is 1 only in HIGH and WAIT_LOW.
REQ-016 LOW -> WAIT_HIGH when the synchronized input is 1, with the stability counter cleared.
REQ-017 WAIT_HIGH -> HIGH when the synchronized input has been 1 for DEB_CYCLES consecutive cycles.
REQ-018 WAIT_HIGH -> LOW immediately when the synchronized input returns to 0 (glitch rejected, no count).
REQ-019 HIGH <-> WAIT_LOW is symmetric to REQ-016..018 with the polarity inverted.
REQ-020 On the cycle the FSM enters HIGH, the lane counter increments by 1 and the lane car_evt bit is 1 for exactly that cycle.
REQ-021 Latency: a clean raw rise first sampled at edge k produces the count update and car_evt at edge k+DEB_CYCLES+2.
REQ-022 Counters are modulo 16 (15 -> 0), with no saturation and no overflow flag; the downstream consumer handles wrap.
REQ-023 clr asserted: all counts are 0 at the next edge; FSM states are unchanged; a simultaneous increment is discarded (clr wins).
REQ-024 Simultaneous events on several lanes in the same cycle each increment their own counter.
REQ-025 Outputs are driven directly from registers; there is no combinational path from the inputs to the outputs.

Reset
REQ-026 reset asserted: all FSMs are set to LOW, stability counters, synchronizer flops, counts and car_evt are set to 0, regardless of clk.
REQ-027 Reset mid-debounce: the in-progress vehicle is lost; a sensor still high at release is counted once after a full DEB_CYCLES qualification.

Configuration
REQ-028 Macro LANE_CAR_DEBOUNCE_EN defined: the debounce FSM is compiled in as per REQ-015..021.
REQ-029 Macro LANE_CAR_DEBOUNCE_EN undefined: the filtered level equals the synchronized input, DEB_CYCLES is ignored, and the count/car_evt occur at edge k+2 on every synchronized rising edge.

Structure
REQ-030 A shared package holds the lane index constants (LANE_NS=3, LANE_SN=2, LANE_EW=1, LANE_WE=0), the debounce state encoding, and the count width constant CNT_W=4.
REQ-031 One sub-module, sensor_debounce (synchronizer plus FSM plus edge strobe), is instantiated four times.

Verification (DEB_CYCLES=4, LANE_CAR_DEBOUNCE_EN defined unless noted)
REQ-032 sensor_ew held high 10 cycles from edge 5 -> car_evt[1] pulses at edge 11 only and count_ew_4b = 1; the other lanes stay 0.
REQ-033 sensor_ns high 3 cycles, then low -> no car_evt and count_ns_4b stays 0 (glitch rejected).
REQ-034 17 clean pulses on sensor_we -> count_we_4b reads 15 after pulse 15, 0 after pulse 16, and 1 after pulse 17.
REQ-035 All four sensors rise together -> all four car_evt bits pulse on the same edge and every count = 1; clr coincident with that edge -> all counts = 0.
REQ-036 reset pulsed while sensor_sn is high in WAIT_HIGH -> count_sn_4b = 0 immediately, then 1 at DEB_CYCLES+2 edges after release.
REQ-037 LANE_CAR_DEBOUNCE_EN undefined, 2-cycle pulse on sensor_ns -> count_ns_4b = 1 at edge k+2.
